// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants for the data-memory port arbiter: memory-op codes,
// pipeline-register mask bits and the arbiter FSM state encoding.
`timescale 1ns/1ps
package dmem_port_arbiter_pkg;

  localparam int MEM_OP_BITS = 2;
  localparam logic [MEM_OP_BITS-1:0] MEM_OP_NOP   = 2'd0;
  localparam logic [MEM_OP_BITS-1:0] MEM_OP_READ  = 2'd1;
  localparam logic [MEM_OP_BITS-1:0] MEM_OP_WRITE = 2'd2;

  localparam int NUM_PIPE_MASKS = 5;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_PC     = 5'b00001;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_IF_ID  = 5'b00010;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_ID_EX  = 5'b00100;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_EX_MEM = 5'b01000;
  localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_MEM_WB = 5'b10000;

  localparam logic [NUM_PIPE_MASKS-1:0] DMEM_STALL_MASK =
    PIPE_REG_PC | PIPE_REG_IF_ID | PIPE_REG_ID_EX | PIPE_REG_EX_MEM;
  localparam logic [NUM_PIPE_MASKS-1:0] DMEM_NOP_MASK = PIPE_REG_MEM_WB;

  typedef enum logic [1:0] {
    DMEM_ARB_IDLE   = 2'd0,
    DMEM_ARB_ACCESS = 2'd1,
    DMEM_ARB_DONE   = 2'd2
  } dmem_arb_state_t;

  function automatic logic mem_op_req(input logic [MEM_OP_BITS-1:0] op);
    return op != MEM_OP_NOP;
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-request priority picker with a round-robin pointer; the pointer flips
// after each enabled cycle in which both lanes requested.
`timescale 1ns/1ps
module dmem_rr_pick (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic grant1
);

  logic ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (en && req0 && req1) begin
      ptr <= ~ptr;
    end
  end

  assign grant1 = (req0 && req1) ? ptr : req1;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Serialises two lanes' loads/stores onto one data-memory port and freezes
// the pipeline until both complete. Round-robin priority with DMEM_ARB_RR_EN.
`timescale 1ns/1ps
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [MEM_OP_BITS-1:0]    ex_mem_mem_op0,
  input  logic [MEM_OP_BITS-1:0]    ex_mem_mem_op1,
  input  logic [ADDR_WIDTH-1:0]     ex_mem_addr0,
  input  logic [ADDR_WIDTH-1:0]     ex_mem_addr1,
  input  logic [DATA_WIDTH-1:0]     ex_mem_wdata0,
  input  logic [DATA_WIDTH-1:0]     ex_mem_wdata1,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [NUM_PIPE_MASKS-1:0] stall0,
  output logic [NUM_PIPE_MASKS-1:0] stall1,
  output logic [NUM_PIPE_MASKS-1:0] nop0,
  output logic [NUM_PIPE_MASKS-1:0] nop1,
  output logic [DATA_WIDTH-1:0]     rdata0,
  output logic [DATA_WIDTH-1:0]     rdata1,
  output logic                      rdata_valid0,
  output logic                      rdata_valid1
);

  dmem_arb_state_t state, state_nxt;

  logic req0, req1, grant1;
  logic cur_lane, served0, served1;
  logic load, load_lane, complete, clr_served;
  logic other_req, other_served;
  logic [MEM_OP_BITS-1:0] load_op;
  logic [ADDR_WIDTH-1:0]  load_addr;
  logic [DATA_WIDTH-1:0]  load_wdata;

  assign req0 = mem_op_req(ex_mem_mem_op0);
  assign req1 = mem_op_req(ex_mem_mem_op1);

`ifdef DMEM_ARB_RR_EN
  dmem_rr_pick u_pick (
    .clk    (clk),
    .reset  (reset),
    .en     (state == DMEM_ARB_IDLE),
    .req0   (req0),
    .req1   (req1),
    .grant1 (grant1)
  );
`else
  assign grant1 = ~req0 & req1;
`endif

  assign other_req    = cur_lane ? req0 : req1;
  assign other_served = cur_lane ? served0 : served1;

  assign load_op    = load_lane ? ex_mem_mem_op1 : ex_mem_mem_op0;
  assign load_addr  = load_lane ? ex_mem_addr1   : ex_mem_addr0;
  assign load_wdata = load_lane ? ex_mem_wdata1  : ex_mem_wdata0;

  assign mem_req = (state == DMEM_ARB_ACCESS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DMEM_ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    load_lane  = 1'b0;
    complete   = 1'b0;
    clr_served = 1'b0;
    stall0     = '0;
    stall1     = '0;
    nop0       = '0;
    nop1       = '0;
    case (state)
      DMEM_ARB_IDLE: begin
        if (req0 || req1) begin
          load      = 1'b1;
          load_lane = grant1;
          state_nxt = DMEM_ARB_ACCESS;
          stall0    = DMEM_STALL_MASK;
          stall1    = DMEM_STALL_MASK;
          nop0      = DMEM_NOP_MASK;
          nop1      = DMEM_NOP_MASK;
        end
      end
      DMEM_ARB_ACCESS: begin
        stall0 = DMEM_STALL_MASK;
        stall1 = DMEM_STALL_MASK;
        nop0   = DMEM_NOP_MASK;
        nop1   = DMEM_NOP_MASK;
        if (mem_ack) begin
          complete = 1'b1;
          // Chain the other lane straight in so mem_req never drops between them.
          if (other_req && !other_served) begin
            load      = 1'b1;
            load_lane = ~cur_lane;
          end else begin
            state_nxt = DMEM_ARB_DONE;
          end
        end
      end
      DMEM_ARB_DONE: begin
        clr_served = 1'b1;
        state_nxt  = DMEM_ARB_IDLE;
      end
      default: state_nxt = DMEM_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_lane     <= 1'b0;
      served0      <= 1'b0;
      served1      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rdata0       <= '0;
      rdata1       <= '0;
      rdata_valid0 <= 1'b0;
      rdata_valid1 <= 1'b0;
    end else begin
      rdata_valid0 <= 1'b0;
      rdata_valid1 <= 1'b0;
      if (complete && !mem_we) begin
        if (cur_lane) begin
          rdata1       <= mem_rdata;
          rdata_valid1 <= 1'b1;
        end else begin
          rdata0       <= mem_rdata;
          rdata_valid0 <= 1'b1;
        end
      end
      if (load) begin
        cur_lane  <= load_lane;
        mem_we    <= (load_op == MEM_OP_WRITE);
        mem_addr  <= load_addr;
        mem_wdata <= load_wdata;
        if (load_lane) served1 <= 1'b1;
        else           served0 <= 1'b1;
      end
      if (clr_served) begin
        served0 <= 1'b0;
        served1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a latency-programmable memory
// model that needs one turnaround cycle after each ack.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [MEM_OP_BITS-1:0] op0, op1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] w0, w1;
  logic mem_ack;
  logic [DW-1:0] mem_rdata;
  logic mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [NUM_PIPE_MASKS-1:0] stall0, stall1, nop0, nop1;
  logic [DW-1:0] rdata0, rdata1;
  logic rdata_valid0, rdata_valid1;

  dmem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_mem_mem_op0 (op0),
    .ex_mem_mem_op1 (op1),
    .ex_mem_addr0   (a0),
    .ex_mem_addr1   (a1),
    .ex_mem_wdata0  (w0),
    .ex_mem_wdata1  (w1),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .stall0         (stall0),
    .stall1         (stall1),
    .nop0           (nop0),
    .nop1           (nop1),
    .rdata0         (rdata0),
    .rdata1         (rdata1),
    .rdata_valid0   (rdata_valid0),
    .rdata_valid1   (rdata_valid1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } port_t;
  typedef struct packed {
    logic          lane;
    logic [DW-1:0] data;
  } rd_t;

  port_t port_q[$];
  rd_t   rd_q[$];

  // Memory model
  logic [DW-1:0] mem [256];
  int  lat   = 1;
  bit  stray = 1'b0;

  initial begin
    int   cnt;
    logic prev;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      prev    = mem_ack;
      mem_ack = 1'b0;
      if (stray) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
      end else if (mem_req === 1'b1) begin
        if (prev) begin
          cnt = 0;
        end else begin
          cnt++;
          if (cnt >= lat) begin
            mem_ack = 1'b1;
            cnt     = 0;
            if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
            else        mem_rdata = mem[mem_addr[7:0]];
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Output monitor: port transactions and read completions
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_ack === 1'b1) begin
        chk("port_txn_expected", port_q.size() != 0, 1);
        if (port_q.size() != 0) begin
          port_t p;
          p = port_q.pop_front();
          chk("port_we", mem_we, p.we);
          chk("port_addr", mem_addr, p.addr);
          if (p.we) chk("port_wdata", mem_wdata, p.wdata);
        end
      end
      if (rdata_valid0 === 1'b1 || rdata_valid1 === 1'b1) begin
        chk("rvalid_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) begin
          rd_t r;
          r = rd_q.pop_front();
          chk("rvalid_lane", {rdata_valid1, rdata_valid0}, r.lane ? 2 : 1);
          chk("rdata", r.lane ? rdata1 : rdata0, r.data);
        end
      end
    end
  end

  task automatic push_lane(input logic lane, input logic [MEM_OP_BITS-1:0] op,
                           input logic [AW-1:0] a, input logic [DW-1:0] w,
                           input logic [DW-1:0] rd);
    port_t p;
    rd_t   r;
    if (op != MEM_OP_NOP) begin
      p.we    = (op == MEM_OP_WRITE);
      p.addr  = a;
      p.wdata = w;
      port_q.push_back(p);
      if (op == MEM_OP_READ) begin
        r.lane = lane;
        r.data = rd;
        rd_q.push_back(r);
      end
    end
  endtask

  // Called just after a rising edge; presents both lanes until the DONE cycle.
  task automatic run_txn(input string name,
                         input logic [MEM_OP_BITS-1:0] o0, input logic [AW-1:0] ad0,
                         input logic [DW-1:0] wd0, input logic [DW-1:0] rd0,
                         input logic [MEM_OP_BITS-1:0] o1, input logic [AW-1:0] ad1,
                         input logic [DW-1:0] wd1, input logic [DW-1:0] rd1,
                         input bit first1, input int l, input int exp_stall);
    int n;
    lat = l;
    if (first1) begin
      push_lane(1'b1, o1, ad1, wd1, rd1);
      push_lane(1'b0, o0, ad0, wd0, rd0);
    end else begin
      push_lane(1'b0, o0, ad0, wd0, rd0);
      push_lane(1'b1, o1, ad1, wd1, rd1);
    end
    op0 = o0; a0 = ad0; w0 = wd0;
    op1 = o1; a1 = ad1; w1 = wd1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall0 == '0) break;
      chk({name, "_stall0"}, stall0, DMEM_STALL_MASK);
      chk({name, "_stall1"}, stall1, DMEM_STALL_MASK);
      chk({name, "_nop0"}, nop0, DMEM_NOP_MASK);
      chk({name, "_nop1"}, nop1, DMEM_NOP_MASK);
      chk({name, "_req"}, mem_req, (n == 0) ? 0 : 1);
      n++;
    end
    chk({name, "_stall_cycles"}, n, exp_stall);
    chk({name, "_done_req"}, mem_req, 0);
    chk({name, "_done_nop"}, nop0, 0);
    @(posedge clk);
    #1;
    op0 = MEM_OP_NOP;
    op1 = MEM_OP_NOP;
    repeat (2) @(negedge clk);
    chk({name, "_port_q_drained"}, port_q.size(), 0);
    chk({name, "_rd_q_drained"}, rd_q.size(), 0);
    chk({name, "_idle_stall"}, stall0, 0);
    @(posedge clk);
    #1;
  endtask

  bit rr;

  initial begin
`ifdef DMEM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 16'hBEEF;
    mem[8'h20] = 16'h2222;
    mem[8'h30] = 16'h3333;

    reset = 1'b1;
    op0 = MEM_OP_NOP; op1 = MEM_OP_NOP;
    a0 = '0; a1 = '0; w0 = '0; w1 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_rvalid", {rdata_valid1, rdata_valid0}, 0);
    chk("rst_stall", {stall1, stall0}, 0);
    chk("rst_nop", {nop1, nop0}, 0);
    @(posedge clk);
    #1;

    run_txn("single_rd", MEM_OP_READ, 16'h0010, 16'h0, 16'hBEEF,
            MEM_OP_NOP, 16'h0, 16'h0, 16'h0, 1'b0, 2, 3);
    chk("single_rd_rdata0", rdata0, 16'hBEEF);
    chk("single_rd_rdata1", rdata1, 0);

    run_txn("dual_rd", MEM_OP_READ, 16'h0020, 16'h0, 16'h2222,
            MEM_OP_READ, 16'h0030, 16'h0, 16'h3333, 1'b0, 1, 4);

    run_txn("dual_rd_ptr", MEM_OP_READ, 16'h0020, 16'h0, 16'h2222,
            MEM_OP_READ, 16'h0030, 16'h0, 16'h3333, rr, 1, 4);

    run_txn("wr_rd", MEM_OP_WRITE, 16'h0040, 16'h1234, 16'h0,
            MEM_OP_READ, 16'h0040, 16'h0, 16'h1234, 1'b0, 1, 4);
    chk("wr_rd_rdata1", rdata1, 16'h1234);
    chk("wr_rd_rdata0_hold", rdata0, 16'h2222);

    run_txn("lane1_wr", MEM_OP_NOP, 16'h0, 16'h0, 16'h0,
            MEM_OP_WRITE, 16'h0050, 16'hA5A5, 16'h0, 1'b1, 3, 4);
    chk("lane1_wr_mem", mem[8'h50], 16'hA5A5);

    // Reset while an access is outstanding, followed by a stray ack
    lat = 100;
    op0 = MEM_OP_READ; a0 = 16'h0010;
    @(negedge clk);
    chk("abort_idle_stall", stall0, DMEM_STALL_MASK);
    @(negedge clk);
    chk("abort_access_req", mem_req, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    op0 = MEM_OP_NOP;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_req_dropped", mem_req, 0);
    chk("abort_stall", stall0, 0);
    stray = 1'b1;
    @(posedge clk);
    #2 stray = 1'b0;
    @(negedge clk);
    chk("stray_ack_seen", mem_ack, 1);
    chk("stray_req", mem_req, 0);
    chk("stray_stall", stall0, 0);
    @(negedge clk);
    chk("stray_rvalid", {rdata_valid1, rdata_valid0}, 0);
    chk("stray_rdata0", rdata0, 0);
    chk("stray_mem_we", mem_we, 0);
    @(posedge clk);
    #1;

    run_txn("post_rst_dual", MEM_OP_READ, 16'h0020, 16'h0, 16'h2222,
            MEM_OP_READ, 16'h0030, 16'h0, 16'h3333, 1'b0, 1, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single data-memory port between the two issue lanes of the dual-issue pipeline at the EX/MEM boundary. When one or both lanes present a load or store, the block serialises them onto the port with a valid/ack handshake and freezes the whole pipeline in lockstep until every pending access has completed. It also returns read data per lane. It sits beside the hazard logic, and its stall/nop masks are OR-ed into the pipeline-register control.

## Interface
- ADDR_WIDTH, 16, data-memory address width
- DATA_WIDTH, 16, data word width
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- ex_mem_mem_op0 / ex_mem_mem_op1  in  `MEM_OP_BITS`  lane memory op (`MEM_OP_NOP`, `MEM_OP_READ`, `MEM_OP_WRITE`)
- ex_mem_addr0 / ex_mem_addr1  in  ADDR_WIDTH  lane address
- ex_mem_wdata0 / ex_mem_wdata1  in  DATA_WIDTH  lane store data
- mem_ack  in  1  one-cycle completion pulse from the memory
- mem_rdata  in  DATA_WIDTH  read data, valid only with mem_ack
- mem_req  out  1  port request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_WIDTH; mem_wdata  out  DATA_WIDTH
- stall0 / stall1  out  `NUM_PIPE_MASKS`  pipe-register hold mask (identical for both lanes)
- nop0 / nop1  out  `NUM_PIPE_MASKS`  pipe-register bubble mask
- rdata0 / rdata1  out  DATA_WIDTH  last read result per lane
- rdata_valid0 / rdata_valid1  out  1  one-cycle pulse when the lane's read completes

## Operation
- A lane requests when its mem_op ≠ `MEM_OP_NOP`.
- FSM states:
  - IDLE: if any lane requests, capture the chosen lane's op, address and wdata into the port registers, mark the lane served, and go to ACCESS.
  - ACCESS: mem_req = 1. On mem_ack:
    - If the other lane requests and is not yet served, load it and stay in ACCESS.
    - Otherwise go to DONE.
  - DONE: stall released for exactly one cycle so EX/MEM advances. Clear the served flags and go to IDLE. Requests present during DONE are ignored.
- Grant order when both lanes request in IDLE: the lane named by the priority pointer goes first. The pointer flips to the other lane after any cycle in which both lanes requested.
- Stall mask: asserted when (IDLE and any request) or ACCESS.
  - stall = `PIPE_REG_PC | PIPE_REG_IF_ID | PIPE_REG_ID_EX | PIPE_REG_EX_MEM`
  - nop = `PIPE_REG_MEM_WB`
  - Both are 0 otherwise.
- Read completion: on mem_ack for a read, rdata of the granted lane ← mem_rdata and its rdata_valid pulses. rdata holds until that lane's next completed read.
- Write completion: mem_ack for a write produces no rdata_valid.
- mem_ack outside ACCESS is ignored.

## Timing
- Reset: state IDLE, priority → lane 0, served flags 0.
  - Outputs: mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, rdata* 0, rdata_valid* 0. Stall/nop masks are 0, given no request.
- Stall asserts combinationally in the same cycle a request appears. mem_req rises on the next edge.
- Single access with ack latency L cycles after mem_req rises: stall held for 1 + L cycles, then DONE.
- Two accesses: the second mem_req follows the first ack back-to-back, with no idle cycle between them.
- Reset mid-ACCESS: abort immediately, return to IDLE and drop mem_req. Any later ack is ignored.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin priority pointer as described above.
- Undefined: fixed priority. Lane 0 always goes first and the pointer register is removed.

## Structure
- Shared package / defines.vh holds:
  - FSM state encoding (`DMEM_ARB_IDLE`, `DMEM_ARB_ACCESS`, `DMEM_ARB_DONE`, 2 bits)
  - `MEM_OP_*` and `PIPE_REG_*` constants
- One natural sub-module: `dmem_rr_pick`, a two-request priority picker holding the pointer. It is replaced by a constant under fixed priority.

## Test plan
- Lane 0 read addr 0x10, lane 1 NOP, ack after 2 cycles with 0xBEEF. Required response:
  - stall asserted for 3 cycles, one DONE cycle
  - rdata0 = 0xBEEF, rdata_valid0 pulses once, rdata_valid1 stays 0
- Both lanes read (0x20, 0x30) after reset, ack latency 1. Required response:
  - lane 0 served first, then lane 1 back-to-back
  - stall held for 4 cycles
  - pointer → lane 1 (under `DMEM_ARB_RR_EN`)
- Repeat the two-lane read with the pointer at lane 1. Required response: lane 1 granted first with RR enabled; lane 0 granted first with RR disabled.
- Lane 0 write 0x40/0x1234, lane 1 read 0x40. Required response:
  - mem_we = 1 then 0
  - rdata1 = memory model value
  - no rdata_valid0
- Reset asserted in ACCESS, then a stray mem_ack arrives. Required response:
  - mem_req = 0 next cycle
  - state IDLE
  - no rdata_valid, stall = 0
